ex_muldiv: RTL and testbench
============================

// Module: ex_muldiv
// PURPOSE
// - Iterative RV32M multiply/divide unit in the EX stage, fed directly by the ID/EX pipeline register.
// - Holds the pipeline via stall while an M-extension instruction computes.
// - Result muxes into the EX result path alongside the ALU and goes to EX/MEM on the done cycle.
// - Targets small area: one shared 32-iteration shift datapath for multiply and divide.
// PARAMETERS
// - XLEN   32  operand/result width; only 32 is supported.
// - ITERS  32  shift-add / restoring-divide iterations; must equal XLEN.
// PORTS
// - clk       in   1      clock
// - rst       in   1      reset, asynchronous, active-high
// - flush     in   1      kill the in-flight op (branch/jump redirect from EX)
// - req       in   1      ID/EX holds a valid M-op; level, held until done
// - md_ctrl   in   3      mdCtrl_e: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
// - rs1_data  in   32     forwarded operand A
// - rs2_data  in   32     forwarded operand B
// - stall     out  1      req & ~done; freezes PC, IF/ID and ID/EX
// - busy      out  1      state != IDLE
// - done      out  1      one-cycle pulse; result valid this cycle
// - result    out  32     final result; held until the next accepted req
// BEHAVIOUR
// - Reset: state=IDLE; stall=0, busy=0, done=0, result=0; counter and internal regs cleared.
// - Reset asserted mid-op aborts to IDLE; no done pulse is produced.
// - States: IDLE -> CALC -> SIGN -> DONE -> IDLE. Special cases take IDLE -> DONE directly.
// - IDLE, req=1, flush=0:
//   - Latch md_ctrl and both operands; later operand changes are ignored.
//   - Take absolute values per signedness: MULHSU treats rs1 signed, rs2 unsigned; *U ops are unsigned.
//   - Record neg_res: product/quotient sign = sA^sB; remainder sign = sA.
// - Divide special cases (IDLE -> DONE; done in cycle 1, where cycle 0 is req's first cycle):
//   - Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1.
//   - Signed overflow, DIV 0x80000000 / -1: DIV -> 0x80000000; REM -> 0.
// - CALC (cycles 1..32): counter counts ITERS-1 down to 0; one iteration per cycle; counter==0 -> SIGN.
//   - Multiply: 64-bit {acc,mplier} shift-add, rs1 as multiplicand.
//   - Divide: restoring division; 33-bit trial subtract; remainder/quotient shift left.
// - SIGN (cycle 33): conditionally two's-complement negate the 64-bit product, or quotient/remainder.
//   - Select the low word (MUL), high word (MULH*), quotient or remainder into result.
// - DONE (cycle 34): done=1 and stall=0 so the pipeline advances. Always -> IDLE next edge.
//   - req seen during DONE belongs to the finishing instruction and is not re-accepted.
// - Back-to-back: the next req is accepted in the first IDLE cycle after DONE.
// - Latency: 35 cycles for normal ops, 2 cycles for special cases.
// - flush=1 in any state: -> IDLE next edge; done is suppressed and result is unchanged.
//   - flush has priority over req in IDLE; the op is not accepted.
// - stall is combinational from req, state and done; it must be low in IDLE when req=0.
// - Width rules:
//   - Remainder register is 33 bits; abs(0x80000000) = 0x80000000, treated as unsigned.
//   - Negation is applied modulo 2^64 (multiply) or 2^32 (divide).
// STRUCTURE
// - Package (types.svh): mdCtrl_e (3-bit enum), mdState_e {MD_IDLE, MD_CALC, MD_SIGN, MD_DONE}.
// - Package also holds a helper predicate md_is_div(mdCtrl_e).
// - Decoder emits md_ctrl and md_en; ID/EX gains md_en and md_ctrl fields.
//   - Both clear to 0 / MUL on the ID/EX clear input.
// - Single module, no sub-modules: FSM, 6-bit counter, shared 64-bit shift register, sign/select logic.
// TESTING
// - MUL 7 * 0xFFFFFFFD -> result 0xFFFFFFEB; done in cycle 34; stall high in cycles 0..33.
// - MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
// - MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
// - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
//   - DIVU 100 / 7 -> 14; REMU -> 2.
// - DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5, both with done in cycle 1.
//   - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
// - flush in cycle 10 -> no done; busy=0 in cycle 11; a new MUL 3*4 issued in cycle 11 -> 12 in cycle 45.
// - rst pulse in cycle 20 of a DIV -> all outputs 0 immediately.
//   - Operands changed after cycle 0 -> result unaffected.
//   - Back-to-back MULs -> second done exactly 35 cycles after the first.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
package ex_muldiv_pkg;

    localparam int MD_XLEN  = 32;
    localparam int MD_ITERS = 32;
    localparam int MD_CNT_W = 6;

    // Encoding follows RV32M funct3, so bit 2 separates divide from multiply.
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_ctrl_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_SIGN = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    function automatic logic md_is_div(md_ctrl_e c);
        return c[2];
    endfunction

    function automatic logic md_is_rem(md_ctrl_e c);
        return (c == MD_REM) || (c == MD_REMU);
    endfunction

    // rs1 is signed for every op except MULHU and the unsigned divides.
    function automatic logic md_a_signed(md_ctrl_e c);
        return (c == MD_MUL) || (c == MD_MULH) || (c == MD_MULHSU) ||
               (c == MD_DIV) || (c == MD_REM);
    endfunction

    // rs2 is signed only for MUL, MULH and the signed divides.
    function automatic logic md_b_signed(md_ctrl_e c);
        return (c == MD_MUL) || (c == MD_MULH) || (c == MD_DIV) || (c == MD_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage. One shared shift
// datapath: {hi,lo} is the {acc,multiplier} pair for multiply and the
// {remainder,dividend/quotient} pair for restoring divide.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req,
    input  logic [2:0]      md_ctrl,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    md_state_e             state_q, state_d;
    md_ctrl_e              op_q, op_d;
    logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN:0]         hi_q, hi_d;       // 33-bit remainder / accumulator
    logic [XLEN-1:0]       lo_q, lo_d;       // multiplier / dividend -> quotient
    logic [XLEN-1:0]       opnd_q, opnd_d;   // |multiplicand| or |divisor|
    logic                  neg_q, neg_d;
    logic [XLEN-1:0]       res_tmp_q, res_tmp_d;
    logic [XLEN-1:0]       result_q, result_d;

    md_ctrl_e              ctrl_in;
    logic                  a_neg, b_neg;
    logic [XLEN-1:0]       abs_a, abs_b;
    logic                  div_zero, div_ovf;
    logic [XLEN+1:0]       mul_sum;
    logic [XLEN:0]         div_shift;
    logic [XLEN+1:0]       div_diff;
    logic [2*XLEN-1:0]     prod, prod_s;
    logic [XLEN-1:0]       quo_s, rem_s;

    assign ctrl_in  = md_ctrl_e'(md_ctrl);
    assign a_neg    = md_a_signed(ctrl_in) & rs1_data[XLEN-1];
    assign b_neg    = md_b_signed(ctrl_in) & rs2_data[XLEN-1];
    // abs(0x80000000) wraps to 0x80000000 and is then used as unsigned.
    assign abs_a    = a_neg ? -rs1_data : rs1_data;
    assign abs_b    = b_neg ? -rs2_data : rs2_data;
    assign div_zero = md_is_div(ctrl_in) && (rs2_data == '0);
    assign div_ovf  = ((ctrl_in == MD_DIV) || (ctrl_in == MD_REM)) &&
                      (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);

    // Shift-add step: add multiplicand when the multiplier LSB is set, then shift right.
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {2'b0, opnd_q} : '0);
    // Restoring step: shift next dividend bit into the remainder and trial-subtract.
    assign div_shift = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b0, opnd_q};

    assign prod   = {hi_q[XLEN-1:0], lo_q};
    assign prod_s = neg_q ? -prod : prod;
    assign quo_s  = neg_q ? -lo_q : lo_q;
    assign rem_s  = neg_q ? -hi_q[XLEN-1:0] : hi_q[XLEN-1:0];

    // Next-state and datapath update for the IDLE -> CALC -> SIGN -> DONE sequence.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opnd_d    = opnd_q;
        neg_d     = neg_q;
        res_tmp_d = res_tmp_q;
        result_d  = result_q;
        case (state_q)
            MD_IDLE: begin
                if (req) begin
                    op_d  = ctrl_in;
                    cnt_d = MD_CNT_W'(ITERS - 1);
                    hi_d  = '0;
                    neg_d = md_is_rem(ctrl_in) ? a_neg : (a_neg ^ b_neg);
                    if (md_is_div(ctrl_in)) begin
                        lo_d   = abs_a;
                        opnd_d = abs_b;
                    end else begin
                        lo_d   = abs_b;
                        opnd_d = abs_a;
                    end
                    if (div_zero) begin
                        res_tmp_d = md_is_rem(ctrl_in) ? rs1_data : '1;
                        state_d   = MD_DONE;
                    end else if (div_ovf) begin
                        res_tmp_d = md_is_rem(ctrl_in) ? '0 : rs1_data;
                        state_d   = MD_DONE;
                    end else begin
                        state_d   = MD_CALC;
                    end
                end
            end
            MD_CALC: begin
                if (md_is_div(op_q)) begin
                    if (!div_diff[XLEN+1]) begin
                        hi_d = div_diff[XLEN:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_d = div_shift;
                        lo_d = {lo_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    hi_d = mul_sum[XLEN+1:1];
                    lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                end
                if (cnt_q == '0) state_d = MD_SIGN;
                else             cnt_d   = cnt_q - 1'b1;
            end
            MD_SIGN: begin
                case (op_q)
                    MD_MUL:                     res_tmp_d = prod_s[XLEN-1:0];
                    MD_MULH, MD_MULHSU, MD_MULHU: res_tmp_d = prod_s[2*XLEN-1:XLEN];
                    MD_DIV, MD_DIVU:            res_tmp_d = quo_s;
                    default:                    res_tmp_d = rem_s;
                endcase
                state_d = MD_DONE;
            end
            default: begin
                result_d = res_tmp_q;
                state_d  = MD_IDLE;
            end
        endcase
        // A redirect kills whatever is in flight and leaves the visible result alone.
        if (flush) begin
            state_d  = MD_IDLE;
            result_d = result_q;
        end
    end

    // State and datapath registers; reset aborts any op without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= MD_IDLE;
            op_q      <= MD_MUL;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            neg_q     <= 1'b0;
            res_tmp_q <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opnd_q    <= opnd_d;
            neg_q     <= neg_d;
            res_tmp_q <= res_tmp_d;
            result_q  <= result_d;
        end
    end

    assign busy   = (state_q != MD_IDLE);
    assign done   = (state_q == MD_DONE) & ~flush;
    assign stall  = req & ~done & ~rst;
    // The fresh result is visible on the done cycle itself, then held.
    assign result = done ? res_tmp_q : result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: driver pushes model results, monitor pops on done.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst, flush, req;
    logic [2:0]  md_ctrl;
    logic [31:0] rs1_data, rs2_data;
    logic        stall, busy, done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        bit          spec;
        int          start;
    } exp_t;

    exp_t        sb_q[$];
    int          nvec = 0;
    int          nerr = 0;
    int          cyc  = 0;
    logic [31:0] last_res = '0;

    ex_muldiv dut (
        .clk(clk), .rst(rst), .flush(flush), .req(req), .md_ctrl(md_ctrl),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .stall(stall), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: RV32M semantics from plain 64-bit / integer arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, output bit spec);
        longint      sa, sb;
        logic [63:0] p;
        int          sq, sr;
        spec = 1'b0;
        if (op < 3'd4) begin
            sa = (op != 3'd3) ? longint'($signed(a)) : longint'({32'b0, a});
            sb = (op <= 3'd1) ? longint'($signed(b)) : longint'({32'b0, b});
            p  = 64'(sa * sb);
            return (op == 3'd0) ? p[31:0] : p[63:32];
        end
        if (b == 32'd0) begin
            spec = 1'b1;
            return op[1] ? a : 32'hFFFF_FFFF;
        end
        if (op == 3'd4 || op == 3'd6) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                spec = 1'b1;
                return (op == 3'd4) ? a : 32'd0;
            end
            sq = $signed(a) / $signed(b);
            sr = $signed(a) % $signed(b);
            return (op == 3'd4) ? 32'(sq) : 32'(sr);
        end
        return (op == 3'd5) ? a / b : a % b;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issue one op (now=1: in the current cycle), hold req until done, scramble operands after cycle 0.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit now, output int dcyc);
        exp_t e;
        bit   ok;
        int   n;
        if (!now) begin @(posedge clk); #1; end
        req = 1'b1; flush = 1'b0; md_ctrl = op; rs1_data = a; rs2_data = b;
        e.res = ref_md(op, a, b, e.spec);
        e.start = cyc;
        sb_q.push_back(e);
        ok = 1'b1; n = 0; dcyc = -1;
        forever begin
            @(negedge clk);
            if (stall !== ~done) ok = 1'b0;
            if (done === 1'b1) begin dcyc = cyc; break; end
            n++;
            if (n > 60) begin
                chk("done_timeout", 64'(n), 64'(35));
                req = 1'b0;
                break;
            end
            @(posedge clk); #1;
            rs1_data = $urandom; rs2_data = $urandom;
        end
        chk("stall_while_busy", 64'(ok), 64'(1));
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 64'(1), 64'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result", 64'(result), 64'(e.res));
                chk("done_latency", 64'(cyc - e.start), e.spec ? 64'(1) : 64'(34));
                last_res = e.res;
            end
        end
    end

    logic [2:0]  d_op[12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] d_a[12]  = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b[12]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                              32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    initial begin
        int d1, d2, s;
        rst = 1'b1; flush = 1'b0; req = 1'b0; md_ctrl = '0; rs1_data = '0; rs2_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", 64'(stall), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_result", 64'(result), 64'(0));
        @(posedge clk); #1 rst = 1'b0;

        // Directed cases, issued back-to-back.
        for (int i = 0; i < 12; i++) do_op(d_op[i], d_a[i], d_b[i], 1'b0, d1);

        // Back-to-back MULs: second done exactly 35 cycles after the first.
        do_op(3'd0, 32'($urandom), 32'($urandom), 1'b0, d1);
        do_op(3'd0, 32'($urandom), 32'($urandom), 1'b0, d2);
        chk("b2b_spacing", 64'(d2 - d1), 64'(35));

        // Flush in cycle 10 of a MUL, then MUL 3*4 issued in cycle 11.
        @(posedge clk); #1;
        req = 1'b1; md_ctrl = 3'd0; rs1_data = $urandom; rs2_data = $urandom; s = cyc;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk) chk("flush_done", 64'(done), 64'(0));
        @(posedge clk); #1 flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'(0));
        chk("flush_result_kept", 64'(result), 64'(last_res));
        do_op(3'd0, 32'd3, 32'd4, 1'b1, d1);
        chk("post_flush_done_cycle", 64'(d1 - s), 64'(45));

        // Flush during the DONE cycle of a special case: no pulse, result unchanged.
        @(posedge clk); #1;
        req = 1'b1; md_ctrl = 3'd5; rs1_data = 32'd5; rs2_data = 32'd0;
        @(posedge clk); #1 flush = 1'b1;
        #1 chk("flush_spec_done", 64'(done), 64'(0));
        chk("flush_spec_result", 64'(result), 64'(last_res));
        @(posedge clk); #1 flush = 1'b0; req = 1'b0;

        // Reset in cycle 20 of a DIV clears every output at once.
        @(posedge clk); #1;
        req = 1'b1; md_ctrl = 3'd4; rs1_data = $urandom; rs2_data = $urandom | 32'd1;
        repeat (20) @(posedge clk);
        #1 rst = 1'b1; req = 1'b0;
        #1;
        chk("rst_stall", 64'(stall), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_result", 64'(result), 64'(0));
        @(posedge clk); #1 rst = 1'b0;
        last_res = '0;

        // Randomized ops with biased operands.
        for (int i = 0; i < 40; i++)
            do_op(3'($urandom_range(0, 7)), pick(), pick(), 1'b0, d1);

        // Idle: no stall without req, result held.
        @(posedge clk); #1 req = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_stall", 64'(stall), 64'(0));
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_result_held", 64'(result), 64'(last_res));
        chk("scoreboard_drained", 64'(sb_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
